ifetch_buffer: RTL

Instruction prefetch stage directly upstream of execute. Generates word addresses for a synchronous-read instruction memory and captures returned instruction words with their PCs in a small FIFO. Presents them to execute through a valid/ready handshake. Execute redirect (taken branch, jump, jal, jr) flushes all buffered and in-flight words and restarts fetch at the redirect target.

---
 rtl/ifetch_buffer_pkg.sv | 15 +
 rtl/ifb_fifo.sv | 41 ++++
 rtl/ifetch_buffer.sv | 72 +++++++
 3 files changed

// File: rtl/ifetch_buffer_pkg.sv
// Shared types and defaults for the instruction prefetch buffer.
package ifetch_buffer_pkg;
  typedef logic [31:0] word_t;

  localparam int    DEPTH_DEF    = 4;
  localparam int    IMEM_AW_DEF  = 8;
  localparam word_t RESET_PC_DEF = 32'h0000_0000;
  // addi x0,x0,0 : what execute substitutes while ins_valid is low
  localparam word_t NOP          = 32'h0000_0013;

  typedef struct packed {
    word_t pc;
    word_t ins;
  } entry_t;
endpackage

// File: rtl/ifb_fifo.sv
// Synchronous FIFO with pointer wrap and occupancy count; flush beats push/pop.
module ifb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rstd,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wptr, rptr;
  logic                    do_push, do_pop, empty, full;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (!rstd || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ifetch_buffer.sv
// Fetch PC generation, one-deep response tracking and redirect handling in front of ifb_fifo.
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter int    DEPTH    = DEPTH_DEF,
  parameter int    IMEM_AW  = IMEM_AW_DEF,
  parameter word_t RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rstd,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               ins_valid,
  output logic [31:0]        ins,
  output logic [31:0]        ins_pc,
  input  logic               ins_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  word_t         fpc, resp_pc;
  logic          inflight;
  logic [CW-1:0] cnt;
  logic          issue, push, pop;
  entry_t        head, wentry;

  // occupancy plus the outstanding response must leave room; pre-pop count on purpose
  assign issue = rstd && !redirect &&
                 (({1'b0, cnt} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = fpc[IMEM_AW-1:0];

  assign push       = inflight && !redirect;
  assign pop        = ins_valid && ins_ready;
  assign wentry.pc  = resp_pc;
  assign wentry.ins = imem_rdata;

  assign ins_valid = (cnt != '0);
  assign ins       = head.ins;
  assign ins_pc    = head.pc;

  always_ff @(posedge clk) begin
    if (!rstd) begin
      fpc      <= RESET_PC;
      inflight <= 1'b0;
      resp_pc  <= '0;
    end else if (redirect) begin
      fpc      <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fpc     <= fpc + 32'd1;
        resp_pc <= fpc;
      end
    end
  end

  ifb_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
    .clk   (clk),
    .rstd  (rstd),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wentry),
    .rdata (head),
    .count (cnt)
  );
endmodule
